model_result_fifo: RTL and testbench

- Downstream stage of the `model` cell; captures each cycle's result pair (o0 on [2:-2], o1 on [-2:2]) into a small synchronous FIFO.
- Presents each entry to the consumer over valid/ready as a single 10-bit word with normalised bit indexing.
- Decouples `model` from consumer back-pressure.
- Reports occupancy plus a sticky overflow flag for dropped writes.

---
 rtl/model_result_pkg.sv | 34 +++
 rtl/model_result_fifo_mem.sv | 37 +++
 rtl/model_result_fifo.sv | 112 +++++++++++
 tb/tb_model_result_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/model_result_pkg.sv
// ---------------------------------------------------------------------------
// model_result_pkg
// Shared definitions for the model result FIFO: the bit ranges of the two
// result fields produced by the `model` cell, the packed word width, and the
// index-preserving packing function.
// ---------------------------------------------------------------------------
package model_result_pkg;

    localparam int O0_MSB = 2;
    localparam int O0_LSB = -2;
    localparam int O1_LSB = -2;
    localparam int O1_MSB = 2;
    localparam int PAIR_W = 10;

    // Packs by bit index, not by position:
    //   word[k+2] = o0[k], word[k+7] = o1[k], k = -2..2.
    // o1 is declared ascending, so its leftmost bit (index -2) lands on word[5]
    // and its rightmost bit (index 2) lands on word[9].
    function automatic logic [PAIR_W-1:0] pack_pair(
        input logic [O0_MSB:O0_LSB] o0,
        input logic [O1_LSB:O1_MSB] o1
    );
        logic [PAIR_W-1:0] w;
        w = '0;
        for (int k = O0_LSB; k <= O0_MSB; k++) begin
            w[k+2] = o0[k];
        end
        for (int k = O1_LSB; k <= O1_MSB; k++) begin
            w[k+7] = o1[k];
        end
        return w;
    endfunction

endpackage

// File: rtl/model_result_fifo_mem.sv
// ---------------------------------------------------------------------------
// model_result_fifo_mem
// DEPTH x PAIR_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset; validity is tracked by
// the owning FIFO.
//   clk      rising-edge clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module model_result_fifo_mem
    import model_result_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [PAIR_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [PAIR_W-1:0] o_rdata
);

    logic [PAIR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/model_result_fifo.sv
// ---------------------------------------------------------------------------
// model_result_fifo
// Captures the `model` cell result pair (o0 [2:-2], o1 [-2:2]) into a small
// FIFO and presents each entry as a 10-bit index-normalised word over
// valid/ready. Reports occupancy and a sticky overflow flag for writes
// dropped while full.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   result pair present this cycle
//   in_o0      o0 result, descending range [2:-2]
//   in_o1      o1 result, ascending range [-2:2]
//   in_ready   FIFO can accept a write
//   out_valid  head entry available
//   out_ready  consumer accepts head entry
//   out_data   head entry (zero when out_valid is low)
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: in_valid seen while full
//   clr_ovf    synchronous clear of overflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module model_result_fifo
    import model_result_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [O0_MSB:O0_LSB] in_o0,
    input  logic [O1_LSB:O1_MSB] in_o1,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAIR_W-1:0]    out_data,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
        $error("model_result_fifo: CNT_W must equal clog2(DEPTH)+1");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;
    logic [PAIR_W-1:0] w_pack;
    logic [PAIR_W-1:0] w_rdata;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr    = in_valid && !w_full;
    assign w_rd    = !w_empty && out_ready;
    assign w_pack  = pack_pair(in_o0, in_o1);

    // DEPTH is a power of two, so plain pointer increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Set takes priority over a same-cycle clear.
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    model_result_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_pack),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Outputs depend only on registered state; stale or uninitialised
    // memory never reaches out_data.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = out_valid ? w_rdata : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_model_result_fifo.sv
module tb_model_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:-2]  in_o0;
    logic [-2:2]  in_o1;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [9:0]   out_data;
    logic [CNT_W-1:0] count;
    logic         overflow;
    logic         clr_ovf;

    always #5 clk = ~clk;

    model_result_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_o0     (in_o0),
        .in_o1     (in_o1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of expected words plus the sticky flag.
    logic [9:0] q[$];
    bit         m_ovf = 1'b0;

    // Low five bits of the word are o0 as written; high five bits are o1
    // read back to front, since o1's leftmost bit carries index -2.
    function automatic logic [9:0] ref_word(input logic [4:0] v0, input logic [4:0] v1);
        logic [4:0] rev;
        for (int i = 0; i < 5; i++) rev[i] = v1[4-i];
        return {rev, v0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count",     32'(count),     32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
        chk("out_data",  32'(out_data),  32'((q.size() != 0) ? q[0] : 10'h000));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Called at posedge+1; drives one cycle, checks at the falling edge,
    // then advances the model across the rising edge.
    task automatic cycle(input bit v, input logic [4:0] d0, input logic [4:0] d1,
                         input bit rdy, input bit clr);
        bit wr, rd;
        in_valid  = v;
        in_o0     = d0;
        in_o1     = d1;
        out_ready = rdy;
        clr_ovf   = clr;
        @(negedge clk);
        check_model();
        wr = v && (q.size() < DEPTH);
        rd = rdy && (q.size() != 0);
        if (v && q.size() == DEPTH) m_ovf = 1'b1;
        else if (clr)               m_ovf = 1'b0;
        @(posedge clk);
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(ref_word(d0, d1));
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_o0 = '0; in_o1 = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Index-based packing of the ascending o1 range
        cycle(1'b1, 5'b10000, 5'b10000, 1'b0, 1'b0);
        #3 chk("pack", 32'(out_data), 32'h030);
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Fill to DEPTH, then one dropped write
        cycle(1'b1, 5'h01, 5'h00, 1'b0, 1'b0);
        cycle(1'b1, 5'h02, 5'h00, 1'b0, 1'b0);
        cycle(1'b1, 5'h04, 5'h00, 1'b0, 1'b0);
        cycle(1'b1, 5'h08, 5'h00, 1'b0, 1'b0);
        #3;
        chk("fill_count",    32'(count),    32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_overflow", 32'(overflow), 32'd0);
        cycle(1'b1, 5'h1F, 5'h1F, 1'b0, 1'b0);
        #3;
        chk("ovf_set",  32'(overflow), 32'd1);
        chk("ovf_head", 32'(out_data), 32'h001);
        chk("ovf_count", 32'(count),   32'd4);

        // Drain with wrap while writing 0x3FF every cycle
        repeat (8) cycle(1'b1, 5'h1F, 5'h1F, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);

        // Simultaneous read/write at occupancy 2
        while (q.size() > 2) cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        while (q.size() < 2) cycle(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b0);
            chk("simul_count", 32'(count), 32'd2);
        end

        // Empty edge: write and read requested together while empty
        while (q.size() > 0) cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, 5'h15, 5'h0A, 1'b1, 1'b0);
        chk("empty_count", 32'(count), 32'd1);
        chk("empty_valid", 32'(out_valid), 32'd1);

        // Overflow set and clear in the same cycle: set wins
        while (q.size() < DEPTH) cycle(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 5'h03, 5'h03, 1'b0, 1'b1);
        #3 chk("ovf_set_wins", 32'(overflow), 32'd1);

        // Asynchronous reset between edges at occupancy 3
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd3);
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_data",  32'(out_data),  32'd0);
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 5'h0C, 5'h11, 1'b0, 1'b0);
        #3 chk("post_rst_head", 32'(out_data), 32'(ref_word(5'h0C, 5'h11)));
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
